// File: rtl/div_if.sv
// Bundle between the EX stage and the multi-cycle divider.
// Handshake: the pipeline holds start (and operands) while stall is high; valid pulses once per completed division.
interface div_if;
    logic        start;
    logic        signed_div;
    logic        annul;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic        valid;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [1:0]  dbg_state;

    modport master (
        output start, signed_div, annul, a, b,
        input  stall, valid, quotient, remainder, dbg_state
    );

    modport slave (
        input  start, signed_div, annul, a, b,
        output stall, valid, quotient, remainder, dbg_state
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for div/divu: 32 iterations on magnitudes, then sign correction.
// Quotient goes to LO and remainder to HI; stall holds the front of the pipeline while busy.
module div_unit (
    input logic  clk,
    input logic  resetn,
    div_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] rem_r;
    logic [31:0] quo_r;
    logic [31:0] dvs_r;
    logic        q_neg;
    logic        r_neg;
    logic [5:0]  cnt;
    logic [31:0] quotient_r;
    logic [31:0] remainder_r;
    logic        valid_r;

    logic        accept;
    logic        use_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] diff;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;

    always_comb begin
        accept     = (state == IDLE) && bus.start && !bus.annul;
        // A divide by zero keeps raw operands so the result is all-ones and the raw dividend.
        use_signed = bus.signed_div && (bus.b != 32'd0);
        a_mag      = (use_signed && bus.a[31]) ? -bus.a : bus.a;
        b_mag      = (use_signed && bus.b[31]) ? -bus.b : bus.b;
        // Trial subtract on the shifted remainder, keeping the bit shifted out of rem as bit 32.
        diff       = {rem_r, quo_r[31]} - {1'b0, dvs_r};
        if (!diff[32]) begin
            rem_nx = diff[31:0];
            quo_nx = {quo_r[30:0], 1'b1};
        end else begin
            rem_nx = {rem_r[30:0], quo_r[31]};
            quo_nx = {quo_r[30:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            rem_r       <= 32'd0;
            quo_r       <= 32'd0;
            dvs_r       <= 32'd0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            cnt         <= 6'd0;
            quotient_r  <= 32'd0;
            remainder_r <= 32'd0;
            valid_r     <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (bus.annul) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state <= CALC;
                            rem_r <= 32'd0;
                            quo_r <= a_mag;
                            dvs_r <= b_mag;
                            q_neg <= use_signed && (bus.a[31] ^ bus.b[31]);
                            r_neg <= use_signed && bus.a[31];
                            cnt   <= 6'd0;
                        end
                    end
                    CALC: begin
                        rem_r <= rem_nx;
                        quo_r <= quo_nx;
                        cnt   <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            state       <= DONE;
                            quotient_r  <= q_neg ? -quo_nx : quo_nx;
                            remainder_r <= r_neg ? -rem_nx : rem_nx;
                            valid_r     <= 1'b1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.stall     = accept || (state == CALC);
    assign bus.valid     = valid_r;
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random divides against an arithmetic model.
// A driver pushes expected results into a queue; a negedge monitor pops and compares on each valid.
module tb_div_unit;
    logic clk;
    logic resetn;
    int   cyc;
    int   tests;
    int   fails;

    div_if bus ();

    div_unit dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_div(input logic [31:0] av, input logic [31:0] bv, input logic sg);
        logic [31:0] q;
        logic [31:0] r;
        int          sa;
        int          sb;
        if (bv == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = av;
        end else if (!sg) begin
            q = av / bv;
            r = av % bv;
        end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            sa = av;
            sb = bv;
            q = sa / sb;
            r = sa % sb;
        end
        return {q, r};
    endfunction

    // ---------------- scoreboard ----------------
    logic [95:0] exp_q[$];
    logic [31:0] last_q;
    logic [31:0] last_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && bus.valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got valid=1 expected no result (cycle %0d)", cyc);
            end else begin
                logic [95:0] e;
                e = exp_q.pop_front();
                check("quotient", bus.quotient, e[63:32]);
                check("remainder", bus.remainder, e[31:0]);
                check("valid_cycle", cyc, e[95:64]);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_div(input logic [31:0] av, input logic [31:0] bv, input logic sg, input logic hold);
        logic [63:0] r;
        int          n;
        r = ref_div(av, bv, sg);
        exp_q.push_back({cyc + 33, r});
        last_q = r[63:32];
        last_r = r[31:0];
        bus.start      = 1'b1;
        bus.signed_div = sg;
        bus.a          = av;
        bus.b          = bv;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.stall) break;
            n++;
            @(posedge clk);
            #1;
            // Operands only matter at acceptance; scramble them afterwards.
            bus.a = $urandom;
            bus.b = $urandom;
            bus.signed_div = 1'($urandom_range(0, 1));
            if (!hold) bus.start = 1'b0;
        end
        check("stall_cycles", n, 33);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        tests = 0;
        fails = 0;
        cyc = 0;
        last_q = 32'd0;
        last_r = 32'd0;
        bus.start = 1'b0;
        bus.signed_div = 1'b0;
        bus.annul = 1'b0;
        bus.a = 32'd0;
        bus.b = 32'd0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check("reset_quotient", bus.quotient, 32'd0);
        check("reset_remainder", bus.remainder, 32'd0);
        check("reset_valid", 32'(bus.valid), 32'd0);
        check("reset_stall", 32'(bus.stall), 32'd0);
        check("reset_state", 32'(bus.dbg_state), 32'd0);
        idle_cycles(1);

        // Directed cases from the plan.
        do_div(32'd100, 32'd7, 1'b0, 1'b1);
        idle_cycles(2);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        do_div(32'd5, 32'd0, 1'b1, 1'b1);
        do_div(32'd5, 32'd0, 1'b0, 1'b1);
        do_div(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b1);
        // Back-to-back: second acceptance lands in cycle 34 of the first.
        do_div(32'd50, 32'd3, 1'b0, 1'b1);
        do_div(32'd9, 32'd9, 1'b0, 1'b1);
        // start dropped after acceptance must not abort.
        do_div(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0);
        idle_cycles(3);

        // Annul in cycle 10: no valid, outputs keep the prior result.
        bus.start = 1'b1;
        bus.signed_div = 1'b0;
        bus.a = 32'd1000;
        bus.b = 32'd3;
        idle_cycles(10);
        bus.annul = 1'b1;
        idle_cycles(1);
        bus.annul = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("annul_stall", 32'(bus.stall), 32'd0);
        check("annul_state", 32'(bus.dbg_state), 32'd0);
        check("annul_keep_q", bus.quotient, last_q);
        check("annul_keep_r", bus.remainder, last_r);
        idle_cycles(40);

        // Reset mid-operation in cycle 20.
        bus.start = 1'b1;
        bus.a = 32'd77;
        bus.b = 32'd5;
        idle_cycles(20);
        resetn = 1'b0;
        #1;
        check("rst_quotient", bus.quotient, 32'd0);
        check("rst_remainder", bus.remainder, 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'd0);
        bus.start = 1'b0;
        idle_cycles(1);
        resetn = 1'b1;
        idle_cycles(40);
        last_q = 32'd0;
        last_r = 32'd0;

        // Random divides, with a bias toward small divisors, negative values and zero.
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 20);
                2: rb = -$urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            do_div(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end

        idle_cycles(5);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the EX stage, working alongside the single-cycle ALU. It executes the `div` (ALU control 4'b0100, signed) and `divu` (4'b0101, unsigned) operations that the ALU reserves but does not compute. It stalls the pipeline while iterating and delivers quotient and remainder for the HI/LO writeback path.

## Interface
Parameters: none. Width is fixed at 32 bits.

Ports:
- clk  in  1  — system clock; all state changes on the rising edge.
- resetn  in  1  — asynchronous, active-low reset.
- start  in  1  — the EX-stage instruction is div/divu. Held high by the pipeline while `stall` is high.
- signed_div  in  1  — 1 = `div` (two's-complement), 0 = `divu`. Sampled on acceptance.
- annul  in  1  — flush from exception or branch squash. Cancels any in-progress operation.
- a  in  32  — dividend (rs). Sampled on acceptance.
- b  in  32  — divisor (rt). Sampled on acceptance.
- stall  out  1  — combinational. Holds IF/ID/EX while a division is being accepted or is iterating.
- valid  out  1  — one-cycle pulse; `quotient`/`remainder` hold a new result.
- quotient  out  32  — registered; goes to LO.
- remainder  out  32  — registered; goes to HI.

## Operation
States: IDLE, CALC, DONE.

Transitions:
- IDLE → CALC when `start`=1 and `annul`=0 (acceptance). On acceptance the block latches:
  - operand magnitudes: |a| and |b| if `signed_div`, else raw a and b;
  - quotient sign = a[31]^b[31] and remainder sign = a[31], both only if `signed_div`;
  - clears the 6-bit iteration counter.
- CALC:
  - Each cycle performs one restoring step on a 64-bit {rem, quo} register: shift left 1, then trial-subtract the divisor magnitude from rem using a 33-bit subtract.
  - If the difference is non-negative, rem takes the difference and quo[0]=1.
  - After the 32nd step the state moves to DONE.
- DONE → IDLE unconditionally after one cycle. A `start` seen in DONE is ignored; a new acceptance happens from IDLE.
- `annul`=1 in any state forces IDLE on the next edge. `annul` has priority over `start`. On annul, `valid` does not pulse and `quotient`/`remainder` keep their previous values.

Outputs:
- `stall` = (IDLE & start & ~annul) | CALC. It is low in DONE.
- On the edge entering DONE, `quotient` and `remainder` load the sign-corrected results:
  - quotient is negated if its sign flag is set;
  - remainder is negated if its sign flag is set.
  - `valid`=1 for the DONE cycle only.

Arithmetic rules:
- Magnitudes and negation wrap mod 2^32.
- Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. No trap is raised.
- Divide by zero (b=0) runs the full latency and yields quotient 0xFFFFFFFF and remainder = a (unsigned view). For a signed divide by zero the sign correction is suppressed, so the result is the same: 0xFFFFFFFF and a. The divider raises no exception.

Reset:
- Reset assertion at any time forces IDLE, counter 0, `valid`=0, `quotient`=0, `remainder`=0. `stall` then follows its equation.

## Timing
Cycle numbering:
- Cycle 0: `start`=1 in IDLE; accepted at the end of cycle 0. `stall`=1.
- Cycles 1–32: CALC; one iteration per cycle. `stall`=1.
- Cycle 33: DONE; `valid`=1, results stable, `stall`=0. The EX instruction advances at the end of cycle 33.

Totals:
- 34 cycles from acceptance cycle to result cycle, inclusive.
- `stall` is high for 33 cycles per division.

Back-to-back divides:
- The next div enters EX in cycle 34, sees IDLE and is accepted then.
- Minimum spacing is 34 cycles.

Other boundary rules:
- `annul` in cycle k (0 ≤ k ≤ 33): IDLE in cycle k+1, `stall`=0 from cycle k+1 unless `start`=1 again, no `valid` pulse. Annul in DONE still leaves `valid` high in that DONE cycle, because the register already loaded.
- `start` dropping during CALC without `annul` (not expected from the pipeline) does not abort the operation.

## Test plan
- Unsigned 100 / 7: `valid` exactly at cycle 33, quotient 14, remainder 2. `stall` high in cycles 0–32.
- Signed 0xFFFFFFF9 (-7) / 2: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Same operands unsigned: quotient 0x7FFFFFFC, remainder 1.
- 0x80000000 / 0xFFFFFFFF:
  - signed → quotient 0x80000000, remainder 0;
  - unsigned → quotient 0, remainder 0x80000000.
- 5 / 0, both signed and unsigned: quotient 0xFFFFFFFF, remainder 5, `valid` at cycle 33.
- Two divides back-to-back (50/3, then 9/9): results 16 r 2 then 1 r 0. Second acceptance in cycle 34, second `valid` in cycle 67.
- Interruptions:
  - `annul` pulsed in cycle 10 → IDLE in cycle 11, no `valid`, outputs keep the prior result.
  - `resetn` low in cycle 20 → all outputs 0 immediately, IDLE after release.
